mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage data-memory access unit of the 5-stage MIPS pipeline. Sits between the
//  EX/MEM register and the MEM/WB register. Turns EX/MEM load/store controls into a
//  req/ack transaction on the data-memory bus, and aligns and extends load data.
//  Drives Memout into MEM/WB and stalls the pipeline while the bus transaction is open.
// PARAMETERS
//  TIMEOUT  16  max BUSY cycles waiting for dmem_ack before abort (>=1)
// PORTS
//  clock        in   1   pipeline clock, all state on posedge
//  resetn       in   1   asynchronous active-low reset
//  MemRead      in   1   load request (EX/MEM M field)
//  MemWrite     in   1   store request (EX/MEM M field)
//  MemSize      in   2   00 byte, 01 half, 10 word, 11 treated as word
//  MemSigned    in   1   1 = sign-extend byte/half loads, 0 = zero-extend
//  ALUOut       in   32  effective byte address
//  StoreData    in   32  rt value for stores, low-aligned
//  Memout       out  32  load result to MEM/WB, registered
//  stall        out  1   freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//  addr_err     out  1   1-cycle pulse: misaligned access rejected
//  bus_err      out  1   1-cycle pulse: TIMEOUT expired, access aborted
//  dmem_req     out  1   bus request, held until ack
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word address, {ALUOut[31:2],2'b00}
//  dmem_be      out  4   byte enables, little-endian, be[i] = byte i
//  dmem_wdata   out  32  store data replicated into the selected lanes
//  dmem_ack     in   1   bus completion; rdata valid in the same cycle
//  dmem_rdata   in   32  read word
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, Memout=0, stall=0, addr_err=0, bus_err=0,
//   dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0, timeout cnt=0.
//  Memory op (mop) = MemRead|MemWrite. If both are 1, the op is treated as a read.
//  Misaligned: half with ALUOut[0]=1, or word with ALUOut[1:0]!=0.
//  FSM IDLE -> BUSY -> DONE -> IDLE. Plus IDLE -> ERR -> IDLE.
//   IDLE: no mop -> stall=0, no bus activity, Memout holds.
//     mop misaligned -> stall=0, next cycle addr_err=1, no request; next=ERR.
//     mop aligned -> stall=1 (combinational), register bus fields; next=BUSY.
//   BUSY: dmem_req=1, stall=1, cnt++. Bus fields are stable until exit.
//     dmem_ack=1 -> read: Memout<=extend(lane(rdata)); write: Memout holds; next=DONE.
//     cnt reaches TIMEOUT without ack -> dmem_req drops, bus_err=1 next cycle,
//     Memout<=0; next=DONE.
//   DONE: stall=0, so the pipeline advances this edge and MEM/WB samples Memout.
//     bus_err/addr_err are valid here. next=IDLE. cnt cleared.
//   ERR: stall=0, addr_err=1, Memout<=0 on entry; next=IDLE.
//  Latency: aligned op with ack on first BUSY cycle = 2 stall cycles, result valid
//   in cycle 3 (DONE). No-mop instructions: 0 stall.
//  Load lane select: byte = rdata[8*a+7:8*a], a=ALUOut[1:0]; half = a[1] ? [31:16] : [15:0].
//  Store: be byte = 1<<a, half = a[1] ? 1100 : 0011, word = 1111.
//   wdata byte = {4{sd[7:0]}}, half = {2{sd[15:0]}}.
//  dmem_we=MemWrite&~MemRead. Loads drive be=1111.
//  Ack outside BUSY is ignored. resetn low mid-BUSY aborts: dmem_req drops
//   asynchronously, and no completion is reported.
// STRUCTURE
//  Shared package mips_pkg: MemSize encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state
//   localparams, lane/byte-enable helper functions.
//  Sub-module mem_load_align (comb: rdata, addr[1:0], size, signed -> 32b result),
//   also reused by any future I-cache-bypass load path.
// TESTING
//  1. Reset mid-BUSY: resetn=0 -> dmem_req=0 and stall=0 in the same cycle; all outputs 0.
//  2. LW 0x100, ack in the 1st BUSY cycle, rdata=0xDEADBEEF -> stall 2 cycles;
//     Memout=0xDEADBEEF in DONE; dmem_addr=0x100, be=1111.
//  3. LB signed @0x103, rdata=0x80112233 -> Memout=0xFFFFFF80.
//     LBU at the same address -> Memout=0x00000080.
//  4. SH @0x102, StoreData=0x0000ABCD -> we=1, be=1100, wdata=0xABCDABCD.
//     Memout unchanged.
//  5. LW @0x101 -> no dmem_req, addr_err pulse 1 cycle, stall=0, Memout=0.
//  6. TIMEOUT=4, ack never arrives -> dmem_req high 4 cycles, then bus_err pulse,
//     Memout=0, FSM back in IDLE; a following LW with ack completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg: shared MEM-stage encodings, FSM states and lane helpers (rev 1.0)
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } mau_state_t;

  // Size code 2'b11 behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      default: is_misaligned = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << a;
      SZ_HALF: store_be = a[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      SZ_BYTE: store_wdata = {4{sd[7:0]}};
      SZ_HALF: store_wdata = {2{sd[15:0]}};
      default: store_wdata = sd;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// mem_access_unit_if: data-memory req/ack bus between MEM stage and memory (rev 1.0)
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// mem_load_align: selects the load lane from a read word and sign/zero extends (rev 1.0)
// ============================================================================
`default_nettype none

module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_BYTE: result = {{24{sign_ext & byte_v[7]}}, byte_v};
      SZ_HALF: result = {{16{sign_ext & half_v[15]}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit: MEM-stage load/store bus sequencer with pipeline stall (rev 1.0)
// ============================================================================
`default_nettype none

module mem_access_unit
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic [1:0]         MemSize,
  input  logic               MemSigned,
  input  logic [31:0]        ALUOut,
  input  logic [31:0]        StoreData,
  output logic [31:0]        Memout,
  output logic               stall,
  output logic               addr_err,
  output logic               bus_err,
  mem_access_unit_if.master  dmem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mau_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       a_q;
  logic [1:0]       size_q;
  logic             sign_q;
  logic [31:0]      load_val;
  logic             mop;
  logic             misal;

  assign mop   = MemRead | MemWrite;
  assign misal = is_misaligned(MemSize, ALUOut[1:0]);

  // Stall rises in the same cycle an aligned access is seen so the pipeline
  // freezes before the bus transaction opens; reset forces it low at once.
  assign stall = resetn & ((state == ST_BUSY) | ((state == ST_IDLE) & mop & ~misal));

  mem_load_align u_load_align (
    .rdata    (dmem.dmem_rdata),
    .addr_lo  (a_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .result   (load_val)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      a_q             <= 2'b00;
      size_q          <= 2'b00;
      sign_q          <= 1'b0;
      Memout          <= 32'h0;
      addr_err        <= 1'b0;
      bus_err         <= 1'b0;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'h0;
      dmem.dmem_be    <= 4'h0;
      dmem.dmem_wdata <= 32'h0;
    end else begin
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mop) begin
            if (misal) begin
              state    <= ST_ERR;
              addr_err <= 1'b1;
              Memout   <= 32'h0;
            end else begin
              state           <= ST_BUSY;
              cnt             <= '0;
              a_q             <= ALUOut[1:0];
              size_q          <= MemSize;
              sign_q          <= MemSigned;
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= MemWrite & ~MemRead;
              dmem.dmem_addr  <= {ALUOut[31:2], 2'b00};
              dmem.dmem_be    <= MemRead ? 4'b1111 : store_be(MemSize, ALUOut[1:0]);
              dmem.dmem_wdata <= store_wdata(MemSize, StoreData);
            end
          end
        end
        ST_BUSY: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) Memout <= load_val;
            state <= ST_DONE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            dmem.dmem_req <= 1'b0;
            bus_err       <= 1'b1;
            Memout        <= 32'h0;
            state         <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        ST_ERR: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit: randomized scoreboard bench for the MEM-stage access unit (rev 1.0)
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        MemRead, MemWrite, MemSigned;
  logic [1:0]  MemSize;
  logic [31:0] ALUOut, StoreData, Memout;
  logic        stall, addr_err, bus_err;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .MemSize   (MemSize),
    .MemSigned (MemSigned),
    .ALUOut    (ALUOut),
    .StoreData (StoreData),
    .Memout    (Memout),
    .stall     (stall),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .dmem      (bus.master)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          aerr;
    bit          berr;
    logic [31:0] memout;
    int          req_cycles;
    int          stall_cycles;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  logic [31:0] exp_memout = 32'h0;
  bit          mon_en = 1'b0;

  // Memory slave: acks after ack_delay BUSY cycles; junk rdata when not acking.
  int          ack_delay = 100;
  logic [31:0] ack_rdata = 32'h0;
  int          k = 0;
  initial begin
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.dmem_req === 1'b1) begin
        bus.dmem_ack   = (k == ack_delay);
        bus.dmem_rdata = (k == ack_delay) ? ack_rdata : $urandom;
        k++;
      end else begin
        bus.dmem_ack = 1'b0;
        k = 0;
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input bit sgn, input logic [1:0] a);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a)) & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * a[1])) & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input int delay, input logic [31:0] rdata);
    res_t r;
    bus_t b;
    int   nbytes, start, guard;
    @(posedge clock);
    #2;
    ack_delay = delay;
    ack_rdata = rdata;
    MemRead   = rd;
    MemWrite  = wr;
    MemSize   = sz;
    MemSigned = sgn;
    ALUOut    = addr;
    StoreData = sd;
    if (rd || wr) begin
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      start  = int'(addr[1:0]) - (int'(addr[1:0]) % nbytes);
      if ((addr % nbytes) != 0) begin
        exp_memout = 32'h0;
        r = '{aerr: 1'b1, berr: 1'b0, memout: 32'h0, req_cycles: 0, stall_cycles: 0};
      end else begin
        b.we   = wr && !rd;
        b.addr = addr & 32'hFFFF_FFFC;
        for (int i = 0; i < 4; i++) begin
          b.be[i] = rd ? 1'b1 : (i >= start && i < start + nbytes);
          b.wdata[8*i +: 8] = sd[8*(i % nbytes) +: 8];
        end
        bus_q.push_back(b);
        r.aerr = 1'b0;
        r.berr = (delay >= TO);
        r.req_cycles = (delay < TO) ? delay + 1 : TO;
        r.stall_cycles = r.req_cycles + 1;
        if (delay >= TO) exp_memout = 32'h0;
        else if (rd) exp_memout = ref_load(rdata, sz, sgn, addr[1:0]);
        r.memout = exp_memout;
      end
      res_q.push_back(r);
    end
    guard = 0;
    do begin
      @(negedge clock);
      guard++;
    end while (stall === 1'b1 && guard < 50);
    if (guard >= 50) begin
      checks++;
      failures++;
      $display("FAIL stall_wait: stall still high after %0d cycles, expected release", guard);
    end
    @(posedge clock);
    #2;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  // Monitor: bus fields on request rise, results on any completion event.
  initial begin
    bit   prev_req;
    int   stall_cnt, req_cnt;
    res_t r;
    bus_t b;
    prev_req = 1'b0;
    stall_cnt = 0;
    req_cnt = 0;
    forever begin
      @(negedge clock);
      if (!mon_en) begin
        prev_req = 1'b0;
        stall_cnt = 0;
        req_cnt = 0;
      end else begin
        if (bus.dmem_req === 1'b1 && !prev_req) begin
          if (bus_q.size() == 0) begin
            check("unexpected_req", 32'(bus.dmem_req), 32'h0);
          end else begin
            b = bus_q.pop_front();
            check("dmem_we", 32'(bus.dmem_we), 32'(b.we));
            check("dmem_addr", bus.dmem_addr, b.addr);
            check("dmem_be", 32'(bus.dmem_be), 32'(b.be));
            if (b.we) check("dmem_wdata", bus.dmem_wdata, b.wdata);
          end
        end
        if (bus.dmem_req === 1'b1) req_cnt++;
        if (addr_err === 1'b1 || bus_err === 1'b1 || (prev_req && bus.dmem_req === 1'b0)) begin
          if (res_q.size() == 0) begin
            check("unexpected_completion", 32'({addr_err, bus_err}), 32'h0);
          end else begin
            r = res_q.pop_front();
            check("addr_err", 32'(addr_err), 32'(r.aerr));
            check("bus_err", 32'(bus_err), 32'(r.berr));
            check("Memout", Memout, r.memout);
            check("stall_at_done", 32'(stall), 32'h0);
            check("req_cycles", 32'(req_cnt), 32'(r.req_cycles));
            check("stall_cycles", 32'(stall_cnt), 32'(r.stall_cycles));
          end
          req_cnt = 0;
          stall_cnt = 0;
        end
        if (stall === 1'b1) stall_cnt++;
        prev_req = (bus.dmem_req === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    logic [31:0] a;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSigned = 1'b0;
    ALUOut = 32'h0; StoreData = 32'h0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_Memout", Memout, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_req", 32'(bus.dmem_req), 32'h0);
    check("rst_we", 32'(bus.dmem_we), 32'h0);
    check("rst_addr", bus.dmem_addr, 32'h0);
    check("rst_be", 32'(bus.dmem_be), 32'h0);
    check("rst_wdata", bus.dmem_wdata, 32'h0);
    check("rst_errs", 32'({addr_err, bus_err}), 32'h0);

    // Reset asserted in the middle of an open read
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #2;
    ack_delay = 100;
    MemRead = 1'b1; MemSize = 2'b10; ALUOut = 32'h200;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("busy_req", 32'(bus.dmem_req), 32'h1);
    check("busy_stall", 32'(stall), 32'h1);
    #1;
    resetn = 1'b0;
    #1;
    check("midrst_req", 32'(bus.dmem_req), 32'h0);
    check("midrst_stall", 32'(stall), 32'h0);
    check("midrst_Memout", Memout, 32'h0);
    check("midrst_addr", bus.dmem_addr, 32'h0);
    check("midrst_be", 32'(bus.dmem_be), 32'h0);
    MemRead = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    exp_memout = 32'h0;
    mon_en = 1'b1;

    do_op(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    do_op(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h80112233);
    do_op(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h80112233);
    do_op(0, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 1, 32'h0);
    do_op(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 32'h0);
    do_op(1, 0, 2'b10, 0, 32'h104, 32'h0, 20, 32'h55AA55AA);
    do_op(1, 0, 2'b10, 0, 32'h108, 32'h0, 2, 32'h12345678);
    do_op(1, 0, 2'b01, 1, 32'h10E, 32'h0, TO - 1, 32'h8001_7FFF);

    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 4);
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      do_op(sel == 1 || sel == 3 || sel == 4, sel == 2 || sel == 3,
            2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), a, $urandom,
            $urandom_range(0, TO + 1), $urandom);
    end

    repeat (5) @(posedge clock);
    check("res_q_drained", 32'(res_q.size()), 32'h0);
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
